ex_mem_pipe: RTL and testbench
==============================

Name: ex_mem_pipe

Overview:
- Pipeline register between the Execute stage and the MemoryAccess stage of the LA32R core.
- Carries the EX result bundle to MEM using a valid/ready handshake.
- Uses a 2-entry skid buffer, so that in_ready is registered and does not depend combinationally on out_ready.
- At capture time, computes the address-misalignment (ALE) flag for loads and stores, so MEM receives a pre-decoded exception bit.

Parameters:
- XLEN, 32, width of pc, inst, lsu_data and ex_result.
- REG_AW, 5, width of the register-file write address.
- CNT_W, 32, width of the stall performance counter.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  pipeline flush (branch mispredict or exception); drops all held entries.
- in_valid  in  1  EX has a valid bundle.
- in_ready  out  1  pipe can accept a bundle this cycle.
- in_pc  in  XLEN  instruction PC.
- in_inst  in  XLEN  raw instruction.
- in_rw_en  in  1  register write enable.
- in_rw_addr  in  REG_AW  destination register.
- in_lsu_op  in  4  LSU opcode: 0000 LD.B, 0001 LD.H, 0010 LD.W, 0100 ST.B, 0101 ST.H, 0110 ST.W, 1000 LD.BU, 1001 LD.HU, 1111 none.
- in_lsu_data  in  XLEN  store data.
- in_ex_result  in  XLEN  ALU result; this is the effective address for LSU ops.
- out_valid  out  1  MEM-side bundle valid.
- out_ready  in  1  MEM consumes the bundle.
- out_pc, out_inst, out_rw_en, out_rw_addr, out_lsu_op, out_lsu_data, out_ex_result  out  (widths as the corresponding in_ fields)  registered bundle.
- out_ale  out  1  misaligned access flag for the bundle on the out_ side.
- stall_cnt  out  CNT_W  count of cycles in which out_valid=1 and out_ready=0.

Behaviour:
- Handshake definitions:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
- Storage: a main register (drives the out_ side) and a skid register, each with its own valid bit.
- States:
  - EMPTY: main invalid, skid invalid.
  - ONE: main valid, skid invalid.
  - FULL: main valid, skid valid.
- in_ready:
  - in_ready = (state != FULL) & !rst.
  - It is a function of registered state only.
- out_valid = main valid.
- Transitions (when flush=0):
  - EMPTY, in_fire -> main <= in; go to ONE.
  - ONE, in_fire & out_fire -> main <= in; stay in ONE.
  - ONE, in_fire & !out_fire -> skid <= in; go to FULL.
  - ONE, !in_fire & out_fire -> go to EMPTY.
  - FULL, out_fire -> main <= skid; go to ONE. No input is accepted in FULL.
  - Any other combination: hold state and data.
- Flush:
  - Next state is EMPTY regardless of in_fire and out_fire.
  - A bundle accepted in the flush cycle is discarded.
  - Payload registers are not cleared; only the valid bits are cleared.
- Ordering: strict FIFO. The skid entry is never presented before the main entry.
- Stability: while out_valid=1 and out_ready=0, every out_ field and out_ale holds stable.
- Latency: 1 cycle from in_fire to out_valid when the pipe is EMPTY or draining.
- Throughput: 1 bundle per cycle when out_ready is held at 1.
- out_ale:
  - Computed from in_lsu_op and in_ex_result[1:0] when the bundle is captured, and stored with the entry (main or skid).
  - 1 when the op is LD.H, LD.HU or ST.H and ex_result[0]=1.
  - 1 when the op is LD.W or ST.W and ex_result[1:0]!=00.
  - 0 for byte ops and non-LSU ops.
- stall_cnt:
  - Increments each cycle in which out_valid=1 and out_ready=0.
  - Saturates at all-ones.
  - Cleared only by rst; flush does not clear it.
- Reset (synchronous):
  - State goes to EMPTY.
  - out_valid=0, in_ready=0 during the rst cycle and 1 on the cycle after.
  - All out_ payload fields = 0, out_ale=0, stall_cnt=0.
  - rst mid-transfer drops both entries; no handshake completes in the rst cycle.
- rst has priority over flush, and flush has priority over fire-based transitions.

Test Plan:
- Streaming: after reset, hold out_ready=1 and send 4 bundles with pc 0x1C000000, +4, +8, +C on consecutive cycles.
  - out_valid is 1 from cycle 1 to cycle 4, pcs appear in order, in_ready stays 1, stall_cnt=0.
- Backpressure: send A then B with out_ready=0.
  - FULL after B; in_ready=0; out_pc=A held for 3 stall cycles; stall_cnt=3.
  - Raise out_ready: A then B delivered, in_ready returns to 1 one cycle after A is consumed.
- Flush in FULL with in_valid=1:
  - Next cycle out_valid=0 and in_ready=1; no further bundle is presented.
  - stall_cnt keeps its value.
- ALE decode:
  - LD.W addr 0x1C000002 -> out_ale=1.
  - ST.H addr 0x1C000002 -> out_ale=0.
  - LD.HU addr 0x1C000003 -> out_ale=1.
  - ST.B addr 0x1C000003 -> out_ale=0.
  - lsu_op=1111 addr 0x3 -> out_ale=0.
- Reset while FULL with in_valid=1:
  - in_ready=0 in the rst cycle.
  - Next cycle: out_valid=0, out_pc=0, stall_cnt=0, in_ready=1.
- Counter saturation: preload via force, or run 2^CNT_W cycles with CNT_W overridden to 4.
  - stall_cnt stops at 0xF.

Source files
------------

// File: rtl/ex_mem_pipe.sv
// ex_mem_pipe: EX -> MEM pipeline register with a 2-entry skid buffer.
//
// The main entry drives the out_ side. The skid entry absorbs one extra bundle
// when MEM stalls. This keeps in_ready a function of registered state only.
// The misaligned-access flag (ALE) is computed when a bundle is captured and
// stored with the entry.
//
// Ports:
//   clk, rst           core clock, synchronous active-high reset
//   flush              drop all held entries (payload registers keep their data)
//   in_valid/in_ready  EX-side handshake
//   in_*               EX result bundle (pc, inst, rw_en, rw_addr, lsu_op,
//                      lsu_data, ex_result)
//   out_valid/out_ready MEM-side handshake
//   out_*              registered bundle, plus out_ale
//   stall_cnt          saturating count of cycles with out_valid & !out_ready
module ex_mem_pipe #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [XLEN-1:0]   in_inst,
  input  logic              in_rw_en,
  input  logic [REG_AW-1:0] in_rw_addr,
  input  logic [3:0]        in_lsu_op,
  input  logic [XLEN-1:0]   in_lsu_data,
  input  logic [XLEN-1:0]   in_ex_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [XLEN-1:0]   out_inst,
  output logic              out_rw_en,
  output logic [REG_AW-1:0] out_rw_addr,
  output logic [3:0]        out_lsu_op,
  output logic [XLEN-1:0]   out_lsu_data,
  output logic [XLEN-1:0]   out_ex_result,
  output logic              out_ale,
  output logic [CNT_W-1:0]  stall_cnt
);

  // One entry packs {pc, inst, rw_en, rw_addr, lsu_op, lsu_data, ex_result, ale}.
  localparam int unsigned BW = 4 * XLEN + REG_AW + 6;

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e          state_q;
  logic [BW-1:0]   main_q;
  logic [BW-1:0]   skid_q;
  logic [BW-1:0]   in_bundle;
  logic            in_ale;
  logic            in_fire;
  logic            out_fire;

  // A halfword access is misaligned when addr[0] is set.
  // A word access is misaligned when either of addr[1:0] is set.
  always_comb begin
    in_ale = 1'b0;
    case (in_lsu_op)
      4'b0001, 4'b1001, 4'b0101: in_ale = in_ex_result[0];
      4'b0010, 4'b0110:          in_ale = |in_ex_result[1:0];
      default:                   in_ale = 1'b0;
    endcase
  end

  assign in_bundle = {in_pc, in_inst, in_rw_en, in_rw_addr, in_lsu_op, in_lsu_data,
                      in_ex_result, in_ale};

  assign in_ready  = (state_q != StFull) & ~rst;
  assign out_valid = (state_q != StEmpty);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  assign {out_pc, out_inst, out_rw_en, out_rw_addr, out_lsu_op, out_lsu_data,
          out_ex_result, out_ale} = main_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StEmpty;
      main_q    <= '0;
      skid_q    <= '0;
      stall_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && stall_cnt != '1) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (flush) begin
        // Only the occupancy is dropped; payload registers keep their data.
        state_q <= StEmpty;
      end else begin
        case (state_q)
          StEmpty: begin
            if (in_fire) begin
              main_q  <= in_bundle;
              state_q <= StOne;
            end
          end
          StOne: begin
            if (in_fire && out_fire) begin
              main_q <= in_bundle;
            end else if (in_fire) begin
              skid_q  <= in_bundle;
              state_q <= StFull;
            end else if (out_fire) begin
              state_q <= StEmpty;
            end
          end
          StFull: begin
            // in_ready is low here, so only the drain path applies.
            if (out_fire) begin
              main_q  <= skid_q;
              state_q <= StOne;
            end
          end
          default: state_q <= StEmpty;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ex_mem_pipe.sv
module tb_ex_mem_pipe;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        rw_en;
    logic [4:0]  rw_addr;
    logic [3:0]  op;
    logic [31:0] data;
    logic [31:0] res;
    logic        ale;
  } bund_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic        exp_ale;
  } ale_vec_t;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic        in_ready, out_valid, out_rw_en, out_ale;
  logic [31:0] in_pc, in_inst, in_lsu_data, in_ex_result;
  logic [31:0] out_pc, out_inst, out_lsu_data, out_ex_result, stall_cnt;
  logic [4:0]  in_rw_addr, out_rw_addr;
  logic [3:0]  in_lsu_op, out_lsu_op;

  // Second instance with a 4-bit counter, used to observe saturation.
  logic        o4_in_ready, o4_out_valid, o4_rw_en, o4_ale;
  logic [31:0] o4_pc, o4_inst, o4_lsu_data, o4_ex_result;
  logic [4:0]  o4_rw_addr;
  logic [3:0]  o4_lsu_op, o4_stall_cnt;

  always #5 clk = ~clk;

  ex_mem_pipe dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .in_rw_en(1'b1), .in_rw_addr(in_rw_addr),
    .in_lsu_op(in_lsu_op), .in_lsu_data(in_lsu_data), .in_ex_result(in_ex_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
    .out_rw_en(out_rw_en), .out_rw_addr(out_rw_addr), .out_lsu_op(out_lsu_op),
    .out_lsu_data(out_lsu_data), .out_ex_result(out_ex_result), .out_ale(out_ale),
    .stall_cnt(stall_cnt)
  );

  ex_mem_pipe #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(o4_in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .in_rw_en(1'b1), .in_rw_addr(in_rw_addr),
    .in_lsu_op(in_lsu_op), .in_lsu_data(in_lsu_data), .in_ex_result(in_ex_result),
    .out_valid(o4_out_valid), .out_ready(out_ready), .out_pc(o4_pc), .out_inst(o4_inst),
    .out_rw_en(o4_rw_en), .out_rw_addr(o4_rw_addr), .out_lsu_op(o4_lsu_op),
    .out_lsu_data(o4_lsu_data), .out_ex_result(o4_ex_result), .out_ale(o4_ale),
    .stall_cnt(o4_stall_cnt)
  );

  // Reference model: FIFO of accepted bundles plus a plain stall counter.
  bund_t           q[$];
  longint unsigned cnt;
  int              total = 0;
  int              bad = 0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic model_ale(input logic [3:0] op, input logic [31:0] addr);
    int unsigned size;
    case (op)
      4'd1, 4'd9, 4'd5: size = 2;
      4'd2, 4'd6:       size = 4;
      default:          size = 1;
    endcase
    return (addr % size) != 0;
  endfunction

  function automatic bund_t mk(input logic [31:0] pc, input logic [3:0] op,
                               input logic [31:0] addr);
    bund_t b;
    b.pc      = pc;
    b.inst    = $urandom;
    b.rw_en   = 1'b1;
    b.rw_addr = 5'($urandom);
    b.op      = op;
    b.data    = $urandom;
    b.res     = addr;
    b.ale     = 1'b0;
    return b;
  endfunction

  // One clock: drive inputs, check outputs against the model mid-cycle,
  // advance the model, then move 1 time unit past the edge.
  task automatic step(input logic r, input logic f, input logic iv, input logic ordy,
                      input bund_t b);
    logic  exp_ready, exp_valid;
    bund_t e;
    rst = r; flush = f; in_valid = iv; out_ready = ordy;
    in_pc = b.pc; in_inst = b.inst; in_rw_addr = b.rw_addr; in_lsu_op = b.op;
    in_lsu_data = b.data; in_ex_result = b.res;
    @(negedge clk);
    exp_ready = !r && (q.size() < 2);
    exp_valid = q.size() > 0;
    check("in_ready", 160'(in_ready), 160'(exp_ready));
    check("out_valid", 160'(out_valid), 160'(exp_valid));
    check("stall_cnt", 160'(stall_cnt), 160'(cnt));
    check("stall_cnt4", 160'(o4_stall_cnt), 160'((cnt > 15) ? 15 : cnt));
    if (exp_valid) begin
      check("out_bundle", 160'({out_pc, out_inst, out_rw_en, out_rw_addr, out_lsu_op,
                                out_lsu_data, out_ex_result, out_ale}), 160'(q[0]));
    end
    if (r) begin
      q.delete();
      cnt = 0;
    end else begin
      if (exp_valid && !ordy) cnt++;
      if (f) begin
        q.delete();
      end else begin
        if (exp_valid && ordy) void'(q.pop_front());
        if (iv && exp_ready) begin
          e     = b;
          e.ale = model_ale(b.op, b.res);
          q.push_back(e);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 1'b0, 1'b0, ordy, mk(32'h0, 4'hF, 32'h0));
  endtask

  logic [3:0] ops[9] = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hF};
  ale_vec_t   vecs[5];

  initial begin
    vecs[0] = '{op: 4'b0010, addr: 32'h1C000002, exp_ale: 1'b1};
    vecs[1] = '{op: 4'b0101, addr: 32'h1C000002, exp_ale: 1'b0};
    vecs[2] = '{op: 4'b1001, addr: 32'h1C000003, exp_ale: 1'b1};
    vecs[3] = '{op: 4'b0100, addr: 32'h1C000003, exp_ale: 1'b0};
    vecs[4] = '{op: 4'b1111, addr: 32'h00000003, exp_ale: 1'b0};

    cnt = 0;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_inst = '0; in_rw_addr = '0; in_lsu_op = 4'hF;
    in_lsu_data = '0; in_ex_result = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("reset_out_pc", 160'(out_pc), 160'(0));
    check("reset_ale", 160'(out_ale), 160'(0));

    // Streaming with out_ready held high.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b1, mk(32'h1C000000 + 4 * i, 4'hF, 0));
    idle(1'b1);
    idle(1'b1);
    check("stream_stall", 160'(stall_cnt), 160'(0));

    // Backpressure: A then B, three stall cycles.
    step(1'b0, 1'b0, 1'b1, 1'b0, mk(32'hA000_0000, 4'hF, 0));
    step(1'b0, 1'b0, 1'b1, 1'b0, mk(32'hB000_0000, 4'hF, 0));
    idle(1'b0);
    idle(1'b0);
    check("bp_stall_cnt", 160'(stall_cnt), 160'(3));
    check("bp_held_pc", 160'(out_pc), 160'(32'hA000_0000));
    check("bp_full_ready", 160'(in_ready), 160'(0));
    idle(1'b1);
    check("bp_ready_back", 160'(in_ready), 160'(1));
    check("bp_second_pc", 160'(out_pc), 160'(32'hB000_0000));
    idle(1'b1);

    // Flush while FULL with an incoming bundle.
    step(1'b0, 1'b0, 1'b1, 1'b0, mk(32'h11, 4'hF, 0));
    step(1'b0, 1'b0, 1'b1, 1'b0, mk(32'h22, 4'hF, 0));
    step(1'b0, 1'b1, 1'b1, 1'b0, mk(32'h33, 4'hF, 0));
    flush = 1'b0; in_valid = 1'b0;
    #1;
    check("flush_valid", 160'(out_valid), 160'(0));
    check("flush_ready", 160'(in_ready), 160'(1));
    check("flush_keeps_cnt", 160'(stall_cnt), 160'(5));
    idle(1'b1);
    idle(1'b0);

    // ALE decode table.
    foreach (vecs[i]) begin
      step(1'b0, 1'b0, 1'b1, 1'b1, mk(32'h1C00_0100 + 4 * i, vecs[i].op, vecs[i].addr));
      check($sformatf("ale_vec%0d", i), 160'(out_ale), 160'(vecs[i].exp_ale));
    end
    idle(1'b1);

    // Reset while FULL with in_valid high.
    step(1'b0, 1'b0, 1'b1, 1'b0, mk(32'h44, 4'hF, 0));
    step(1'b0, 1'b0, 1'b1, 1'b0, mk(32'h55, 4'hF, 0));
    step(1'b1, 1'b0, 1'b1, 1'b0, mk(32'h66, 4'hF, 0));
    rst = 1'b0; in_valid = 1'b0;
    #1;
    check("rst_valid", 160'(out_valid), 160'(0));
    check("rst_pc", 160'(out_pc), 160'(0));
    check("rst_cnt", 160'(stall_cnt), 160'(0));
    check("rst_ready", 160'(in_ready), 160'(1));

    // Long stall: the 4-bit counter must stop at 0xF.
    step(1'b0, 1'b0, 1'b1, 1'b0, mk(32'h77, 4'h2, 32'h4));
    for (int i = 0; i < 20; i++) idle(1'b0);
    check("sat_cnt4", 160'(o4_stall_cnt), 160'(4'hF));
    check("sat_cnt32", 160'(stall_cnt), 160'(20));
    idle(1'b1);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(99, 0) < 2), ($urandom_range(99, 0) < 5),
           1'($urandom), ($urandom_range(99, 0) < 70),
           mk($urandom, ops[$urandom_range(8, 0)], $urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
